// File: rtl/counter_pkg.sv
// Shared types and helpers for the cascaded counter: direction/mode encodings
// and a width-agnostic minimum used for clipping load values.
package counter_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  // Operands are zero-extended by the caller; stage widths up to 32 bits.
  function automatic logic [31:0] sat_min(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/counter_stage.sv
// One counter stage: DW-bit register, terminal detect, up/down next value,
// clear > load > step priority. A held stage ignores its step.
module counter_stage
  import counter_pkg::*;
#(
  parameter int  DW   = 8,
  parameter type dw_t = logic [DW-1:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  input  logic up,
  input  logic clr,
  input  logic ld,
  input  dw_t  ld_val,
  input  dw_t  max,
  input  logic hold,
  output dw_t  cnt,
  output logic term
);

  cnt_dir_e dir;
  dw_t      nxt;
  dw_t      ld_clip;

  assign dir     = cnt_dir_e'(up);
  assign ld_clip = dw_t'(sat_min(32'(ld_val), 32'(max)));

  always_comb begin
    term = (dir == DIR_UP) ? (cnt >= max) : (cnt == '0);
  end

  // A count left above a lowered max wraps to 0 going up and snaps to max going down.
  always_comb begin
    nxt = cnt;
    if (dir == DIR_UP) begin
      nxt = (cnt < max) ? cnt + dw_t'(1) : '0;
    end else begin
      nxt = ((cnt == '0) || (cnt > max)) ? max : cnt - dw_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_clip;
    end else if (step && !hold) begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/counter_cascade.sv
// Multi-stage cascaded counter: NSTG stages rippling carries upward from
// stage 0, with wrap/saturate mode, per-stage carries and sticky overflow.
module counter_cascade
  import counter_pkg::*;
#(
  parameter int  NSTG = 4,
  parameter int  DW   = 8,
  parameter int  SAT  = 0,
  parameter type dw_t = logic [DW-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             ld,
  input  dw_t [NSTG-1:0]   ld_val,
  input  dw_t [NSTG-1:0]   max,
  output dw_t [NSTG-1:0]   cnt,
  output logic [NSTG-1:0]  tc,
  output logic             co,
  output logic             ovf
);

  localparam cnt_mode_e MODE = (SAT != 0) ? MODE_SAT : MODE_WRAP;

  logic [NSTG-1:0] term;
  logic [NSTG-1:0] step;
  logic            hold;

  assign co   = tc[NSTG-1];
  assign hold = (MODE == MODE_SAT) && co;

  for (genvar i = 0; i < NSTG; i++) begin : g_stage
    // Flat AND-reduction per carry rather than a serial chain of tc terms.
    assign tc[i] = en & (&term[i:0]);

    if (i == 0) begin : g_first
      assign step[i] = en;
    end else begin : g_next
      assign step[i] = tc[i-1];
    end

    counter_stage #(
      .DW   (DW),
      .dw_t (dw_t)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (step[i]),
      .up     (up),
      .clr    (clr),
      .ld     (ld),
      .ld_val (ld_val[i]),
      .max    (max[i]),
      .hold   (hold),
      .cnt    (cnt[i]),
      .term   (term[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (clr || ld) begin
      ovf <= 1'b0;
    end else if (co) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_cascade.sv
// Bench for counter_cascade: wrap and saturate instances driven in parallel,
// checked against a per-stage arithmetic reference plus directed constants.
module tb_counter_cascade;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            up;
  logic            clr;
  logic            ld;
  logic [1:0][3:0] ld_val;
  logic [1:0][3:0] mx;
  logic [1:0][3:0] cnt_w, cnt_s;
  logic [1:0]      tc_w, tc_s;
  logic            co_w, co_s, ovf_w, ovf_s;

  int checks   = 0;
  int failures = 0;

  int mc [2][2];
  bit mo [2];

  counter_cascade #(.NSTG(2), .DW(4), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .max(mx), .cnt(cnt_w), .tc(tc_w), .co(co_w), .ovf(ovf_w)
  );

  counter_cascade #(.NSTG(2), .DW(4), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .max(mx), .cnt(cnt_s), .tc(tc_s), .co(co_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_term(input int c, input int m);
    return up ? (c >= m) : (c == 0);
  endfunction

  function automatic logic [1:0] exp_tc(input int k);
    logic t0, t1;
    t0 = en & is_term(mc[k][0], int'(mx[0]));
    t1 = t0 & is_term(mc[k][1], int'(mx[1]));
    return {t1, t0};
  endfunction

  function automatic int nxt(input int c, input int m);
    if (up) return (c < m) ? c + 1 : 0;
    return ((c == 0) || (c > m)) ? m : c - 1;
  endfunction

  function automatic logic [7:0] exp_cnt(input int k);
    return 8'(mc[k][1] * 16 + mc[k][0]);
  endfunction

  task automatic model_step(input int k);
    logic [1:0] t;
    int n0, n1;
    t = exp_tc(k);
    if (clr) begin
      mc[k][0] = 0; mc[k][1] = 0; mo[k] = 0;
    end else if (ld) begin
      for (int j = 0; j < 2; j++)
        mc[k][j] = (ld_val[j] < mx[j]) ? int'(ld_val[j]) : int'(mx[j]);
      mo[k] = 0;
    end else begin
      if (t[1]) mo[k] = 1;
      if (!(k == 1 && t[1])) begin
        n0 = en   ? nxt(mc[k][0], int'(mx[0])) : mc[k][0];
        n1 = t[0] ? nxt(mc[k][1], int'(mx[1])) : mc[k][1];
        mc[k][0] = n0; mc[k][1] = n1;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mc[k][0] = 0; mc[k][1] = 0; mo[k] = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic [1:0] tw, ts;
    #1;
    tw = exp_tc(0);
    ts = exp_tc(1);
    check("tc_w", 32'(tc_w), 32'(tw));
    check("co_w", 32'(co_w), 32'(tw[1]));
    check("tc_s", 32'(tc_s), 32'(ts));
    check("co_s", 32'(co_s), 32'(ts[1]));
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("cnt_w", 32'(cnt_w), 32'(exp_cnt(0)));
    check("ovf_w", 32'(ovf_w), 32'(mo[0]));
    check("cnt_s", 32'(cnt_s), 32'(exp_cnt(1)));
    check("ovf_s", 32'(ovf_s), 32'(mo[1]));
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; en = 1'b1; up = 1'b0; clr = 1'b0; ld = 1'b0;
    ld_val = '0; mx = {4'd5, 4'd9};

    // reset state: down with en shows carry on all-zero stages
    #3;
    check("rst_cnt", 32'(cnt_w), 32'h0);
    check("rst_ovf", 32'(ovf_w), 32'h0);
    check("rst_co_down", 32'(co_w), 32'h1);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    cycle();

    // wrap up through 59 and saturate hold
    up = 1'b1; en = 1'b1;
    repeat (59) cycle();
    #1;
    check("wrap_59", 32'(cnt_w), 32'h59);
    check("wrap_co", 32'(co_w), 32'h1);
    cycle();
    check("wrap_0", 32'(cnt_w), 32'h00);
    check("wrap_ovf", 32'(ovf_w), 32'h1);
    repeat (5) cycle();
    check("sat_hold", 32'(cnt_s), 32'h59);
    check("sat_ovf", 32'(ovf_s), 32'h1);
    check("sat_co", 32'(co_s), 32'h1);

    // load clips, clear beats load
    en = 1'b0; ld = 1'b1; ld_val = {4'd3, 4'd12};
    cycle();
    check("ld_clip", 32'(cnt_w), 32'h39);
    check("ld_ovf", 32'(ovf_w), 32'h0);
    clr = 1'b1;
    cycle();
    check("clr_ld", 32'(cnt_w), 32'h00);
    clr = 1'b0; ld = 1'b0;

    // down from zero
    up = 1'b0; en = 1'b1;
    #1;
    check("dn_co", 32'(co_w), 32'h1);
    cycle();
    check("dn_59", 32'(cnt_w), 32'h59);
    cycle();
    check("dn_58", 32'(cnt_w), 32'h58);

    // lowered max and zero max
    en = 1'b0; ld = 1'b1; ld_val = {4'd1, 4'd7};
    cycle();
    ld = 1'b0; up = 1'b1; en = 1'b1; mx[0] = 4'd4;
    #1;
    check("mx_tc0", 32'(tc_w[0]), 32'h1);
    cycle();
    check("mx_20", 32'(cnt_w), 32'h20);
    mx[0] = 4'd0;
    cycle();
    cycle();
    check("mx0_40", 32'(cnt_w), 32'h40);

    // async reset mid-count with ovf set
    mx = {4'd5, 4'd9}; clr = 1'b1; en = 1'b0;
    cycle();
    clr = 1'b0; en = 1'b1;
    repeat (93) cycle();
    check("pre_rst_cnt", 32'(cnt_w), 32'h33);
    check("pre_rst_ovf", 32'(ovf_w), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_cnt", 32'(cnt_w), 32'h00);
    check("arst_ovf", 32'(ovf_w), 32'h0);
    check("arst_cnt_s", 32'(cnt_s), 32'h00);
    #1 rst_n = 1'b1;
    model_reset();
    cycle();
    check("arst_resume", 32'(cnt_w), 32'h01);

    // randomized run against the reference
    repeat (400) begin
      en     = ($urandom_range(0, 3) != 0);
      up     = 1'($urandom);
      clr    = ($urandom_range(0, 31) == 0);
      ld     = ($urandom_range(0, 15) == 0);
      ld_val = 8'($urandom);
      if ($urandom_range(0, 19) == 0) mx = 8'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_cascade.md
# counter_cascade

Parametrised multi-stage cascaded counter for timers, baud/tick dividers and mixed-radix time bases (e.g. sec/min/hour). Each of `NSTG` stages counts modulo its own runtime `max`. Stages ripple carries from stage 0, the least significant, upward. Adds up/down direction, synchronous load and clear, wrap-or-saturate mode, per-stage carry outputs and a sticky overflow flag.

## Interface
Parameters:
- `NSTG`, 4, number of stages (≥1)
- `DW`, 8, width of each stage
- `SAT`, 0, 0 = wrap at terminal, 1 = saturate at terminal
- `dw_t`, `logic [DW-1:0]`, per-stage value type

Ports:
- `clk` input 1: clock
- `rst_n` input 1: reset. Asynchronous, active-low.
- `en` input 1: count enable for stage 0
- `up` input 1: 1 = count up, 0 = count down
- `clr` input 1: synchronous clear
- `ld` input 1: synchronous load
- `ld_val` input `dw_t [NSTG-1:0]`: load values
- `max` input `dw_t [NSTG-1:0]`: per-stage terminal value. Quasi-static, but may change at any time.
- `cnt` output `dw_t [NSTG-1:0]`: stage counts, registered
- `tc` output `NSTG`: per-stage carry-out, combinational
- `co` output 1: chain carry-out, equal to `tc[NSTG-1]`
- `ovf` output 1: sticky overflow, registered

## Operation
- **Stage terminal condition:**
  - up: `term[i] = cnt[i] >= max[i]`
  - down: `term[i] = cnt[i] == 0`
- **Carry chain:** `tc[i] = en & term[0] & … & term[i]`. Stage 0 steps when `en` is set; stage i>0 steps when `tc[i-1]` is set.
- **Up step:** `cnt < max` → `cnt+1`; otherwise → 0. A count above a lowered `max` therefore wraps to 0 and carries.
- **Down step:** `cnt == 0` → `max`; `cnt > max` → `max`; otherwise → `cnt-1`.
- **SAT=1:** when `co` is set, no stage changes and the whole chain holds its value. Below terminal, behaviour is identical to wrap mode.
- **Priority per cycle:** `clr` > `ld` > step.
  - `clr`: all `cnt` = 0 and `ovf` = 0. `tc` and `co` still reflect current state and `en`.
  - `ld`: `cnt[i] = min(ld_val[i], max[i])` and `ovf` = 0.
- **`ovf`:** set on the edge where `co` = 1 and neither `clr` nor `ld` is set. It remains set until `clr`, `ld` or reset.
- **`up` changes:** a change takes effect in the same cycle (terminal detection and step direction). No pipeline state is flushed.
- **Arithmetic:** each stage is strictly DW bits. `cnt+1` is evaluated only when `cnt < max`, so it never overflows DW.
- **`max[i]` = 0:** stage i is permanently terminal and stays at 0. It acts as a pass-through of the carry.

## Timing
- **Reset values:** `cnt` = 0 (all stages), `ovf` = 0. While in reset, `tc` and `co` follow the combinational rule. With `up`=0 and `en`=1, `co`=1 during reset, because every stage is at 0.
- **Latency:**
  - `cnt` updates one cycle after `en`, `ld` or `clr` is sampled.
  - `tc` and `co` are valid in the same cycle as the terminal state and `en`. This is a zero-cycle carry that ripples combinationally through all stages.
  - `ovf` rises one cycle after `co`.
- **Reset mid-operation:** `cnt` and `ovf` clear immediately, asynchronously. Normal counting resumes on the first edge after `rst_n` rises.
- **`en` low:** all `cnt` hold and `tc` = 0, regardless of `ld_val` or `max` changes. An exception is a `cnt` above a changed `max`: it stays until the next step, `ld` or `clr`.
- **Critical path:** the carry chain is O(NSTG) compare+AND. Implementation keeps it as a flat AND-reduction over the `term` vector.

## Structure
- **Package `counter_pkg`:**
  - `cnt_dir_e` enum: `DIR_DN`=0, `DIR_UP`=1
  - `cnt_mode_e`: `MODE_WRAP`, `MODE_SAT`
  - shared helper function `sat_min(a,b)`
  - `dw_t` stays a module type parameter
- **Sub-module `counter_stage`:**
  - contents: one DW-bit register, terminal detect, up/down next-value logic, `ld`/`clr` priority
  - ports: `clk`, `rst_n`, `step`, `up`, `clr`, `ld`, `ld_val`, `max`, `hold`, `cnt`, `term`
  - the top level generates `NSTG` instances plus the carry AND-chain and the `ovf` register

## Test plan
All scenarios use `NSTG`=2, `DW`=4, `max`={5,9} (stage1, stage0), i.e. modulo 60.

- **Wrap up:** reset, then `up`=1, `en`=1 for 59 cycles.
  - `cnt`={5,9}, `co`=1 in that cycle
  - next edge: `cnt`={0,0}, `ovf`=1
  - `tc[0]` pulses at every x9
- **Down:** reset, then `up`=0, `en`=1.
  - `co`=1 in the first cycle
  - next edge: `cnt`={5,9}; then {5,8}, and so on down
- **Saturate:** `SAT`=1, count up 59 times, then hold `en`=1 for 5 more cycles.
  - `cnt` stays at {5,9}
  - `co`=1 every cycle; `ovf`=1
- **Load/clear priority:**
  - `ld`=1 with `ld_val`={3,12} → `cnt`={3,9} (stage0 clipped to 9) and `ovf` cleared
  - `ld`=1 with `clr`=1 → `cnt`={0,0}
- **Max change:** at `cnt`={1,7}, change `max[0]` to 4 while `en`=1.
  - `tc[0]`=1 in the same cycle
  - next: `cnt`={2,0}
  - with `max[0]`=0: stage0 stays 0 and stage1 steps every `en` cycle
- **Async reset:** at `cnt`={3,3} with `ovf`=1, pulse `rst_n` low between edges.
  - `cnt`={0,0` and `ovf`=0 before the next edge
  - counting resumes one cycle after release
